mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU on the two source operands read from the register file (rs, rt) and holds the results in the architectural HI/LO registers. It also accepts MTHI/MTLO writes. The execute stage issues a one-cycle start and stalls MFHI/MFLO while busy is high.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_muldiv_unit_if.sv | 30 +++
 rtl/mips_muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide unit: op and FSM encodings
// plus iteration count and divide-by-zero constant.
package mips_pkg;

  localparam int unsigned ITER          = 32;
  localparam logic [31:0] DIVZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Execute-stage <-> mul/div unit connection: issue, MTHI/MTLO writes, HI/LO readback.
interface mips_muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One iteration per cycle on magnitudes, sign fix-up in a final cycle.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mips_muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ITER);

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  state_e             state;
  state_e             state_nxt;
  op_e                op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               is_div;
  logic               issue_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [CNT_W-1:0]   div_idx;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CALC;
      S_CALC:  if (cnt == CNT_W'(ITER - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue decode
  always_comb begin
    issue_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    neg_a        = issue_signed && bus.operand_a[WIDTH-1];
    neg_b        = issue_signed && bus.operand_b[WIDTH-1];
    is_div       = (op_q == OP_DIVU) || (op_q == OP_DIV);
  end

  // One shift-add or restoring-divide step; divide keeps {remainder, quotient} in acc
  always_comb begin
    acc_hi     = acc[2*WIDTH-1:WIDTH];
    acc_lo     = acc[WIDTH-1:0];
    div_idx    = CNT_W'(ITER - 1) - cnt;
    mul_addend = b_mag[cnt] ? a_mag : '0;
    mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
    div_trial  = {acc_hi, a_mag[div_idx]};
    div_diff   = div_trial - {1'b0, b_mag};
    if (!is_div)
      acc_nxt = {mul_sum, acc_lo[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_nxt = {div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
    else
      acc_nxt = {div_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
  end

  // Sign correction; 2W-bit product negate done as borrow across the halves
  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (!is_div) begin
      if (sign_a ^ sign_b) begin
        fix_lo = twos_neg(acc_lo);
        fix_hi = (acc_lo == '0) ? twos_neg(acc_hi) : ~acc_hi;
      end
    end else if (b_mag == '0) begin
      fix_hi = a_raw;
      fix_lo = WIDTH'(DIVZ_QUOTIENT);
    end else begin
      if (sign_a ^ sign_b) fix_lo = twos_neg(acc_lo);
      if (sign_a)          fix_hi = twos_neg(acc_hi);
    end
  end

  // Architectural HI/LO and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= (state_nxt != S_IDLE);
      done_q <= (state == S_FIX);
      if (state == S_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (!busy_q) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          op_q   <= bus.op;
          sign_a <= neg_a;
          sign_b <= neg_b;
          a_mag  <= neg_a ? twos_neg(bus.operand_a) : bus.operand_a;
          b_mag  <= neg_b ? twos_neg(bus.operand_b) : bus.operand_b;
          a_raw  <= bus.operand_a;
          acc    <= '0;
          cnt    <= '0;
        end
      end
      S_CALC: begin
        acc <= acc_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: arithmetic/timing reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  bit          chk_en = 1'b0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] p_res = '0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;

  mips_muldiv_unit_if #(.WIDTH(32)) bus ();
  mips_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural result: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_MULT:  r = 64'(sa * sb);
      default: begin
        if (b == 32'h0)          r = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIVU)  r = {a % b, a / b};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-level reference: 33 busy cycles after an accepted start, then done with result
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= p_res[63:32];
          m_lo   <= p_res[31:0];
        end
      end else begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
        if (bus.start) begin
          p_res  <= ref_result(bus.op, bus.operand_a, bus.operand_b);
          m_busy <= 1'b1;
          m_left <= 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("hi",   bus.hi, m_hi);
      check("lo",   bus.lo, m_lo);
    end
  end

  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    t0            = cyc;
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
  endtask

  task automatic wait_done(input string name, output int busy_cnt);
    busy_cnt = 0;
    while (!bus.done && cyc < t0 + 100) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check({name, " latency"}, 32'(cyc - t0 + 1), 32'd34);
  endtask

  task automatic run_op(input string name, input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bc;
    issue(op, a, b);
    wait_done(name, bc);
    check({name, " hi"}, bus.hi, exp_hi);
    check({name, " lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    logic [63:0] pin;
    int          bc;
    bit          seen_done;

    bus.start = 1'b0; bus.op = OP_MULTU; bus.operand_a = '0; bus.operand_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    pin = ref_result(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("model mult", pin[31:0], 32'hFFFF_FFFA);
    pin = ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("model div", pin[63:32], 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult", bc);
    check("mult busy cycles", 32'(bc), 32'd33);
    check("mult busy at done", 32'(bus.busy), 32'd0);
    check("mult hi", bus.hi, 32'hFFFF_FFFF);
    check("mult lo", bus.lo, 32'hFFFF_FFFA);

    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu /0",   OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
    run_op("div /0",    OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("div 7/-2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

    // Start and MTHI while busy are both dropped
    issue(OP_MULTU, 32'd5, 32'd6);
    while (cyc < t0 + 4) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd99; bus.operand_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 9) @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    wait_done("busy rules", bc);
    check("busy rules hi", bus.hi, 32'd0);
    check("busy rules lo", bus.lo, 32'd30);

    // Back-to-back start in the done cycle, with an MTLO in the same cycle
    bus.lo_we = 1'b1; bus.wdata = 32'hAA;
    issue(OP_DIVU, 32'd100, 32'd7);
    bus.lo_we = 1'b0;
    check("b2b mtlo", bus.lo, 32'hAA);
    check("b2b busy", 32'(bus.busy), 32'd1);
    wait_done("b2b", bc);
    check("b2b hi", bus.hi, 32'd2);
    check("b2b lo", bus.lo, 32'd14);

    // Reset mid-flight abandons the operation
    issue(OP_MULT, 32'h0001_2345, 32'h77);
    while (cyc < t0 + 14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset hi", bus.hi, 32'd0);
    check("midreset lo", bus.lo, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("midreset no done", 32'(seen_done), 32'd0);

    run_op("mult min*2", OP_MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
